// File: rtl/seg7_scan.sv
// Eight-digit multiplexed hex display driver with a shadowed load committed at frame boundaries.
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seg7_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_i,
   input  logic [7:0]  dp_i,
   input  logic [7:0]  blank_i,
   input  logic        load_i,
   output logic        pending_o,
   output logic [7:0]  disp_seg_o,
   output logic [7:0]  disp_an_o
);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_p0;
   logic [2:0]       idx_p0;
   logic [31:0]      shadow_data;
   logic [31:0]      active_data;
   logic [7:0]       shadow_dp;
   logic [7:0]       active_dp;
   logic             pending;
   logic             tick;
   logic             frame_end;
   logic             commit;
   logic [3:0]       nib;
   logic             hide;
   logic [7:0]       seg_nxt;
   logic [7:0]       an_nxt;
   logic [7:0]       seg_p1;
   logic [7:0]       an_p1;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0:    hex_font = 7'b1000000;
         4'h1:    hex_font = 7'b1111001;
         4'h2:    hex_font = 7'b0100100;
         4'h3:    hex_font = 7'b0110000;
         4'h4:    hex_font = 7'b0011001;
         4'h5:    hex_font = 7'b0010010;
         4'h6:    hex_font = 7'b0000010;
         4'h7:    hex_font = 7'b1111000;
         4'h8:    hex_font = 7'b0000000;
         4'h9:    hex_font = 7'b0010000;
         4'hA:    hex_font = 7'b0001000;
         4'hB:    hex_font = 7'b0000011;
         4'hC:    hex_font = 7'b1000110;
         4'hD:    hex_font = 7'b0100001;
         4'hE:    hex_font = 7'b0000110;
         default: hex_font = 7'b0001110;
      endcase
   endfunction

   assign tick      = (div_p0 == DIV_LAST);
   assign frame_end = tick && (idx_p0 == 3'd7);
   assign commit    = frame_end && pending;

   // Stage 0: scan timing, shadow capture and frame-boundary commit
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_p0      <= '0;
         idx_p0      <= '0;
         shadow_data <= '0;
         shadow_dp   <= '0;
         active_data <= '0;
         active_dp   <= '0;
         pending     <= 1'b0;
      end else begin
         div_p0 <= tick ? '0 : div_p0 + DIV_W'(1);
         if (tick) begin
            idx_p0 <= idx_p0 + 3'd1;
         end
         if (commit) begin
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
         end
         // A load on the commit cycle refills the shadow, so pending stays set.
         if (load_i) begin
            shadow_data <= data_i;
            shadow_dp   <= dp_i;
            pending     <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [2:0] msd;

   always_comb begin
      msd = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (active_data[4*k +: 4] != 4'd0) begin
            msd = 3'(k);
         end
      end
   end
`endif

   always_comb begin
      nib  = active_data[{idx_p0, 2'b00} +: 4];
      hide = blank_i[idx_p0];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (idx_p0 > msd) begin
         hide = 1'b1;
      end
`endif
      an_nxt = ~(8'b1 << idx_p0);
      if (hide) begin
         seg_nxt = 8'hFF;
      end else begin
         seg_nxt = {~active_dp[idx_p0], hex_font(nib)};
      end
   end

   // Stage 1: registered display drive
   always_ff @(posedge clk) begin
      if (!reset) begin
         seg_p1 <= 8'hFF;
         an_p1  <= 8'hFF;
      end else begin
         seg_p1 <= seg_nxt;
         an_p1  <= an_nxt;
      end
   end

   assign disp_seg_o = seg_p1;
   assign disp_an_o  = an_p1;
   assign pending_o  = pending;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: directed scenarios plus random traffic against a cycle-count based display model.
module tb_seg7_scan;
   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] LEAD_ZERO_IMG = 8'hFF;
`else
   localparam logic [7:0] LEAD_ZERO_IMG = 8'hC0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_i = '0;
   logic [7:0]  dp_i = '0;
   logic [7:0]  blank_i = '0;
   logic        load_i = 1'b0;
   logic        pending_o;
   logic [7:0]  disp_seg_o;
   logic [7:0]  disp_an_o;

   seg7_scan #(.SCAN_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .data_i     (data_i),
      .dp_i       (dp_i),
      .blank_i    (blank_i),
      .load_i     (load_i),
      .pending_o  (pending_o),
      .disp_seg_o (disp_seg_o),
      .disp_an_o  (disp_an_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int t      = 0;

   logic [31:0] m_act = '0;
   logic [31:0] m_sh = '0;
   logic [7:0]  m_act_dp = '0;
   logic [7:0]  m_sh_dp = '0;
   logic        m_pend = 1'b0;
   logic [7:0]  exp_an = 8'hFF;
   logic [7:0]  exp_seg = 8'hFF;

   // Lit segments of each hex glyph, by segment letter.
   string font_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [7:0] digit_image(input logic [31:0] val, input logic [7:0] dp,
                                              input logic [7:0] blk, input int k);
      logic [6:0] s;
      string      lit;
      int         nib;
      nib = int'(val[4*k +: 4]);
      if (blk[k]) return 8'hFF;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      begin
         int lead;
         lead = 0;
         for (int j = 0; j < 8; j++) if (val[4*j +: 4] != 4'd0) lead = j;
         if (k > lead) return 8'hFF;
      end
`endif
      s   = 7'h7F;
      lit = font_lit[nib];
      for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
      return {~dp[k], s};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, expv, t);
      end
   endtask

   task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p);
      int dig;
      load_i = ld;
      data_i = d;
      dp_i   = p;
      @(posedge clk);
      if (!reset) begin
         t = 0; m_act = '0; m_act_dp = '0; m_sh = '0; m_sh_dp = '0; m_pend = 1'b0;
         exp_an = 8'hFF; exp_seg = 8'hFF;
      end else begin
         t++;
         dig     = ((t - 1) / DIV) % 8;
         exp_an  = ~(8'h01 << dig);
         exp_seg = digit_image(m_act, m_act_dp, blank_i, dig);
         if ((t % FRAME == 0) && m_pend) begin
            m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
         end
         if (ld) begin
            m_sh = d; m_sh_dp = p; m_pend = 1'b1;
         end
      end
      #1;
      check("an", {24'h0, disp_an_o}, {24'h0, exp_an});
      check("seg", {24'h0, disp_seg_o}, {24'h0, exp_seg});
      check("pending", {31'h0, pending_o}, {31'h0, m_pend});
      load_i = 1'b0;
   endtask

   task automatic run_to(input int target);
      for (int n = 0; n < 400 && t < target; n++) step(1'b0, 32'h0, 8'h0);
   endtask

   task automatic run_no_a(input int target);
      for (int n = 0; n < 400 && t < target; n++) begin
         step(1'b0, 32'h0, 8'h0);
         checks++;
         assert (disp_seg_o !== 8'h88) passed++;
         else begin
            fails++;
            $error("FAIL no_A: observed %h expected not 88 (t=%0d)", disp_seg_o, t);
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (3) step(1'b0, 32'h0, 8'h0);
      check("rst_an", {24'h0, disp_an_o}, 32'hFF);
      check("rst_seg", {24'h0, disp_seg_o}, 32'hFF);

      // Release with zero data: scan FE..7F then wrap
      reset = 1'b1;
      step(1'b0, 32'h0, 8'h0);
      check("first_an", {24'h0, disp_an_o}, 32'hFE);
      check("first_seg", {24'h0, disp_seg_o}, 32'hC0);
      run_to(33);
      check("wrap_an", {24'h0, disp_an_o}, 32'hFE);
      run_to(40);

      // Mid-frame load committed at the next boundary
      step(1'b1, 32'h01234567, 8'h00);
      check("pend_set", {31'h0, pending_o}, 32'h1);
      run_to(65);
      check("d0_seven", {24'h0, disp_seg_o}, 32'hF8);
      run_to(93);
      check("d7_lead", {24'h0, disp_seg_o}, {24'h0, LEAD_ZERO_IMG});
      run_to(96);

      // Last load wins within a frame
      step(1'b1, 32'hAAAAAAAA, 8'h00);
      step(1'b0, 32'h0, 8'h00);
      step(1'b0, 32'h0, 8'h00);
      step(1'b1, 32'h55555555, 8'h00);
      run_no_a(129);
      check("d0_five", {24'h0, disp_seg_o}, 32'h92);
      run_no_a(160);

      // Load coincident with commit
      step(1'b1, 32'h11111111, 8'h00);
      run_to(191);
      step(1'b1, 32'hFFFFFFFF, 8'h00);
      check("pend_hold", {31'h0, pending_o}, 32'h1);
      step(1'b0, 32'h0, 8'h00);
      check("d0_one", {24'h0, disp_seg_o}, 32'hF9);
      run_to(225);
      check("d0_F", {24'h0, disp_seg_o}, 32'h8E);
      check("pend_clr", {31'h0, pending_o}, 32'h0);

      // Decimal point, forced blank and leading zeros
      blank_i = 8'h02;
      step(1'b1, 32'h00000010, 8'h01);
      run_to(257);
      check("d0_dp", {24'h0, disp_seg_o}, 32'h40);
      run_to(261);
      check("d1_blank", {24'h0, disp_seg_o}, 32'hFF);
      run_to(265);
      check("d2_lead", {24'h0, disp_seg_o}, {24'h0, LEAD_ZERO_IMG});
      run_to(288);
      blank_i = 8'h00;

      // Random traffic, including live blanking
      for (int n = 0; n < 400; n++) begin
         blank_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         step($urandom_range(0, 9) == 0, $urandom, 8'($urandom));
      end
      blank_i = 8'h00;

      // Reset while a load is pending
      step(1'b1, 32'hDEADBEEF, 8'hFF);
      check("pre_rst_pend", {31'h0, pending_o}, 32'h1);
      reset = 1'b0;
      step(1'b1, 32'h12345678, 8'hFF);
      check("rst_an2", {24'h0, disp_an_o}, 32'hFF);
      check("rst_seg2", {24'h0, disp_seg_o}, 32'hFF);
      check("rst_pend2", {31'h0, pending_o}, 32'h0);
      reset = 1'b1;
      step(1'b0, 32'h0, 8'h00);
      check("rel_seg", {24'h0, disp_seg_o}, 32'hC0);
      run_to(FRAME + 8);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles each digit is driven; legal range 2..2^20.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port data_i  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k.
REQ-005 The block SHALL have port dp_i  input  8  decimal-point request per digit, active-high.
REQ-006 The block SHALL have port blank_i  input  8  per-digit force-blank, active-high.
REQ-007 The block SHALL have port load_i  input  1  single-cycle strobe that captures data_i and dp_i into the shadow register.
REQ-008 The block SHALL have port pending_o  output  1  high while shadow data waits for a frame boundary.
REQ-009 The block SHALL have port disp_seg_o  output  8  active-low segments: bit0=a ... bit6=g, bit7=dp.
REQ-010 The block SHALL have port disp_an_o  output  8  active-low digit enables; bit k selects digit k.

Function
REQ-011 A divider counter SHALL count 0..SCAN_DIV-1; tick is the cycle in which it equals SCAN_DIV-1, after which it wraps to 0.
REQ-012 The digit index SHALL advance 0->1->...->7->0 on each tick; the tick with index 7 is the frame boundary.
REQ-013 On load_i=1 the shadow SHALL take data_i/dp_i and pending_o SHALL be 1 from the next cycle.
REQ-014 At a frame boundary with pending_o=1 the active register SHALL take the shadow and pending_o SHALL clear, unless load_i is also 1.
REQ-015 If load_i coincides with a commit: active takes the old shadow, shadow takes the new data_i, pending_o stays 1.
REQ-016 Repeated load_i before a commit SHALL overwrite the shadow; last load wins, and no intermediate value is shown.
REQ-017 disp_an_o and disp_seg_o SHALL be registered, reflecting the current index and active register with one cycle latency; exactly one disp_an_o bit SHALL be low outside reset.
REQ-018 Nibble decode SHALL be the standard hex font 0-F (e.g. 0 -> seg[6:0]=7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-019 A digit with blank_i[k]=1 SHALL drive disp_seg_o=8'hFF while its anode is still enabled; blank_i is sampled live, not shadowed.
REQ-020 dp SHALL be driven low only when the active dp bit is 1 and the digit is not blanked.

Reset
REQ-021 With reset=0 at a clk edge: divider=0, index=0, active=0, shadow=0, pending_o=0, disp_an_o=8'hFF, disp_seg_o=8'hFF.
REQ-022 The first edge after reset release SHALL drive digit 0 (disp_an_o=8'hFE) showing active nibble 0.
REQ-023 Reset asserted mid-frame SHALL discard pending shadow data; reset SHALL take priority over load_i.

Configuration
REQ-024 With SEG7_LEADING_ZERO_BLANK_EN defined, digits above the most significant non-zero nibble of active SHALL be blanked as if blank_i were set; digit 0 SHALL never be auto-blanked.
REQ-025 Without SEG7_LEADING_ZERO_BLANK_EN, every digit SHALL show its nibble, including leading zeros; port list is identical in both builds.

Verification (SCAN_DIV=4)
REQ-026 The bench SHALL cover reset release with data 0 -> disp_an_o FE,FD,...,7F each held 4 cycles, disp_seg_o=8'hC0 throughout, cycling back to FE.
REQ-027 The bench SHALL cover load_i with 32'h01234567 mid-frame -> pending_o=1 until the index-7 tick; from the next frame digit0 seg=8'hF8 ("7") and digit7 seg=8'hC0.
REQ-028 The bench SHALL cover load_i of 32'hAAAAAAAA, then 32'h55555555 three cycles later in the same frame -> only "5" is displayed; "A" never appears.
REQ-029 The bench SHALL cover load_i of 32'hFFFFFFFF coincident with a frame-boundary commit of pending 32'h11111111 -> next frame shows "1", pending_o stays 1, the frame after shows "F".
REQ-030 The bench SHALL cover dp_i=8'h01, blank_i=8'h02, data 32'h00000010 -> digit0 seg=8'h40; digit1 seg=8'hFF; with SEG7_LEADING_ZERO_BLANK_EN, digits 2-7 seg=8'hFF, without it seg=8'hC0.
REQ-031 The bench SHALL cover reset pulled low for one cycle while pending_o=1 -> all outputs 8'hFF next cycle, pending_o=0, active=0 after release.
